// File: rtl/id_stage_param_if.sv
// ID/EXE pipeline-register bundle: the decoded instruction handed from ID to EXE.
interface id_stage_param_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  id_valid;
  logic [DATA_W-1:0]     pc_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic                  wb_en_out;
  logic                  imm_out;
  logic                  branch_out;
  logic                  s_out;
  logic [3:0]            exe_cmd_out;
  logic [DATA_W-1:0]     val_rn_out;
  logic [DATA_W-1:0]     val_rm_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [REG_ADDR_W-1:0] src1_out;
  logic [REG_ADDR_W-1:0] src2_out;
  logic [23:0]           signed_imm_out;
  logic [11:0]           shift_op_out;
  logic [3:0]            status_out;

  modport master (
    output id_valid, pc_out, mem_read_out, mem_write_out, wb_en_out, imm_out,
           branch_out, s_out, exe_cmd_out, val_rn_out, val_rm_out, dest_out,
           src1_out, src2_out, signed_imm_out, shift_op_out, status_out
  );

  modport slave (
    input  id_valid, pc_out, mem_read_out, mem_write_out, wb_en_out, imm_out,
           branch_out, s_out, exe_cmd_out, val_rn_out, val_rm_out, dest_out,
           src1_out, src2_out, signed_imm_out, shift_op_out, status_out
  );
endinterface

// File: rtl/id_stage_param.sv
// ARM decode stage: field decode, control, register file, hazard detection and
// the ID/EXE pipeline register with flush / freeze / bubble handling.
module id_stage_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int WB_BYPASS  = 1,
  parameter int FWD_EN     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  if_valid,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [31:0]           instr_in,
  input  logic [3:0]            status_in,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_mem_read,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  hazard_out,
  output logic [15:0]           hazard_cycles,
  id_stage_param_if.master      idex
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] raddr_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic              mem_read;
    logic              mem_write;
    logic              wb_en;
    logic              imm;
    logic              branch;
    logic              s;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    raddr_t            dest;
    raddr_t            src1;
    raddr_t            src2;
    logic [23:0]       signed_imm;
    logic [11:0]       shift_op;
    logic [3:0]        status;
  } idex_t;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  raddr_t     rn;
  raddr_t     rd;
  raddr_t     rm;

  assign cond   = instr_in[31:28];
  assign mode   = instr_in[27:26];
  assign i_bit  = instr_in[25];
  assign opcode = instr_in[24:21];
  assign s_bit  = instr_in[20];
  assign rn     = raddr_t'(instr_in[19:16]);
  assign rd     = raddr_t'(instr_in[15:12]);
  assign rm     = raddr_t'(instr_in[3:0]);

  // Condition evaluation against NZCV
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ok;

  assign {flag_n, flag_z, flag_c, flag_v} = status_in;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'd0:  cond_ok = flag_z;
      4'd1:  cond_ok = ~flag_z;
      4'd2:  cond_ok = flag_c;
      4'd3:  cond_ok = ~flag_c;
      4'd4:  cond_ok = flag_n;
      4'd5:  cond_ok = ~flag_n;
      4'd6:  cond_ok = flag_v;
      4'd7:  cond_ok = ~flag_v;
      4'd8:  cond_ok = flag_c & ~flag_z;
      4'd9:  cond_ok = ~flag_c | flag_z;
      4'd10: cond_ok = (flag_n == flag_v);
      4'd11: cond_ok = (flag_n != flag_v);
      4'd12: cond_ok = ~flag_z & (flag_n == flag_v);
      4'd13: cond_ok = flag_z | (flag_n != flag_v);
      4'd14: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Control unit
  logic       supported;
  logic [3:0] exe_cmd;
  logic       ctl_mem_read;
  logic       ctl_mem_write;
  logic       ctl_wb_en;
  logic       ctl_branch;
  logic       ctl_s;

  always_comb begin
    supported     = 1'b0;
    exe_cmd       = CMD_NOP;
    ctl_mem_read  = 1'b0;
    ctl_mem_write = 1'b0;
    ctl_wb_en     = 1'b0;
    ctl_branch    = 1'b0;
    ctl_s         = 1'b0;
    case (mode)
      2'b00: begin
        supported = 1'b1;
        ctl_wb_en = 1'b1;
        ctl_s     = s_bit;
        case (opcode)
          OP_MOV: exe_cmd = CMD_MOV;
          OP_MVN: exe_cmd = CMD_MVN;
          OP_ADD: exe_cmd = CMD_ADD;
          OP_ADC: exe_cmd = CMD_ADC;
          OP_SUB: exe_cmd = CMD_SUB;
          OP_SBC: exe_cmd = CMD_SBC;
          OP_AND: exe_cmd = CMD_AND;
          OP_ORR: exe_cmd = CMD_ORR;
          OP_EOR: exe_cmd = CMD_EOR;
          OP_CMP: begin
            exe_cmd   = CMD_SUB;
            ctl_wb_en = 1'b0;
          end
          OP_TST: begin
            exe_cmd   = CMD_AND;
            ctl_wb_en = 1'b0;
          end
          default: begin
            supported = 1'b0;
            ctl_wb_en = 1'b0;
            ctl_s     = 1'b0;
          end
        endcase
      end
      2'b01: begin
        supported     = 1'b1;
        exe_cmd       = CMD_ADD;
        ctl_mem_read  = s_bit;
        ctl_wb_en     = s_bit;
        ctl_mem_write = ~s_bit;
      end
      2'b10: begin
        supported  = i_bit;
        ctl_branch = i_bit;
      end
      default: supported = 1'b0;
    endcase
  end

  // Operand usage
  logic   is_branch;
  logic   is_str;
  logic   rn_used;
  logic   two_src;
  raddr_t src2;

  assign is_branch = (mode == 2'b10) & i_bit;
  assign is_str    = (mode == 2'b01) & ~s_bit;
  assign rn_used   = ~(((mode == 2'b00) & ((opcode == OP_MOV) | (opcode == OP_MVN))) | is_branch);
  assign two_src   = (~i_bit & (mode == 2'b00)) | is_str;
  assign src2      = is_str ? rd : rm;

  // Hazard detection; reset drops the freeze request immediately
  logic exe_hit;
  logic mem_hit;
  logic raw_hazard;

  assign exe_hit = exe_wb_en & ((rn_used & (rn == exe_dest)) | (two_src & (src2 == exe_dest)));
  assign mem_hit = mem_wb_en & ((rn_used & (rn == mem_dest)) | (two_src & (src2 == mem_dest)));
  assign raw_hazard = (FWD_EN != 0) ? (exe_hit & exe_mem_read) : (exe_hit | mem_hit);
  assign hazard_out = if_valid & raw_hazard & ~flush & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hazard_cycles <= '0;
    else if (hazard_out & ~freeze & ~flush & (hazard_cycles != '1))
      hazard_cycles <= hazard_cycles + 16'd1;
  end

  // Register file
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs <= '{default: '0};
    else if (wb_en)
      regs[wb_addr] <= wb_data;
  end

  assign val_rn = ((WB_BYPASS != 0) && wb_en && (wb_addr == rn))   ? wb_data : regs[rn];
  assign val_rm = ((WB_BYPASS != 0) && wb_en && (wb_addr == src2)) ? wb_data : regs[src2];

  // ID/EXE register: data fields always load; control is zeroed on flush or bubble
  logic  bubble;
  logic  kill;
  idex_t d;
  idex_t q;

  assign bubble = ~if_valid | ~cond_ok | ~supported | hazard_out;
  assign kill   = flush | bubble;

  always_comb begin
    d            = '0;
    d.pc         = pc_in;
    d.imm        = i_bit;
    d.val_rn     = val_rn;
    d.val_rm     = val_rm;
    d.dest       = rd;
    d.src1       = rn;
    d.src2       = src2;
    d.signed_imm = instr_in[23:0];
    d.shift_op   = instr_in[11:0];
    d.status     = status_in;
    if (!kill) begin
      d.valid     = 1'b1;
      d.mem_read  = ctl_mem_read;
      d.mem_write = ctl_mem_write;
      d.wb_en     = ctl_wb_en;
      d.branch    = ctl_branch;
      d.s         = ctl_s;
      d.exe_cmd   = exe_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (flush || !freeze)
      q <= d;
  end

  assign idex.id_valid       = q.valid;
  assign idex.pc_out         = q.pc;
  assign idex.mem_read_out   = q.mem_read;
  assign idex.mem_write_out  = q.mem_write;
  assign idex.wb_en_out      = q.wb_en;
  assign idex.imm_out        = q.imm;
  assign idex.branch_out     = q.branch;
  assign idex.s_out          = q.s;
  assign idex.exe_cmd_out    = q.exe_cmd;
  assign idex.val_rn_out     = q.val_rn;
  assign idex.val_rm_out     = q.val_rm;
  assign idex.dest_out       = q.dest;
  assign idex.src1_out       = q.src1;
  assign idex.src2_out       = q.src2;
  assign idex.signed_imm_out = q.signed_imm;
  assign idex.shift_op_out   = q.shift_op;
  assign idex.status_out     = q.status;

endmodule

// File: tb/tb_id_stage_param.sv
// Scoreboard bench: dut_a (bypass on, no forwarding) and dut_b (bypass off, forwarding).
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, freeze, if_valid;
  logic [31:0] pc_in, instr_in;
  logic [3:0]  status_in;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exe_wb_en, exe_mem_read, mem_wb_en;
  logic [3:0]  exe_dest, mem_dest;
  logic        haz_a, haz_b;
  logic [15:0] hcyc_a, hcyc_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  id_stage_param_if #(.DATA_W(32), .REG_ADDR_W(4)) bus_a ();
  id_stage_param_if #(.DATA_W(32), .REG_ADDR_W(4)) bus_b ();

  id_stage_param #(.DATA_W(32), .REG_ADDR_W(4), .WB_BYPASS(1), .FWD_EN(0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .if_valid(if_valid),
    .pc_in(pc_in), .instr_in(instr_in), .status_in(status_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .hazard_out(haz_a), .hazard_cycles(hcyc_a), .idex(bus_a)
  );

  id_stage_param #(.DATA_W(32), .REG_ADDR_W(4), .WB_BYPASS(0), .FWD_EN(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .if_valid(if_valid),
    .pc_in(pc_in), .instr_in(instr_in), .status_in(status_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .hazard_out(haz_b), .hazard_cycles(hcyc_b), .idex(bus_b)
  );

  typedef enum int unsigned {
    A_VALID, A_PC, A_CMD, A_WBEN, A_MEMRD, A_MEMWR, A_BR, A_IMM, A_DEST,
    A_RN, A_RM, A_SHIFT, A_SIMM, A_HCYC, B_VALID, B_CMD, B_RM, B_HCYC
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      A_VALID: return 32'(bus_a.id_valid);
      A_PC:    return bus_a.pc_out;
      A_CMD:   return 32'(bus_a.exe_cmd_out);
      A_WBEN:  return 32'(bus_a.wb_en_out);
      A_MEMRD: return 32'(bus_a.mem_read_out);
      A_MEMWR: return 32'(bus_a.mem_write_out);
      A_BR:    return 32'(bus_a.branch_out);
      A_IMM:   return 32'(bus_a.imm_out);
      A_DEST:  return 32'(bus_a.dest_out);
      A_RN:    return bus_a.val_rn_out;
      A_RM:    return bus_a.val_rm_out;
      A_SHIFT: return 32'(bus_a.shift_op_out);
      A_SIMM:  return 32'(bus_a.signed_imm_out);
      A_HCYC:  return 32'(hcyc_a);
      B_VALID: return 32'(bus_b.id_valid);
      B_CMD:   return 32'(bus_b.exe_cmd_out);
      B_RM:    return bus_b.val_rm_out;
      B_HCYC:  return 32'(hcyc_b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic set_instr(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    instr_in = instr;
    pc_in    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; if_valid = 1'b0;
    pc_in = '0; instr_in = '0; status_in = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    exe_wb_en = 1'b0; exe_dest = '0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = '0;
    #12;
    check("rst_valid_a", observe(A_VALID), 32'd0);
    check("rst_hcyc_a",  observe(A_HCYC),  32'd0);
    check("rst_rn_a",    observe(A_RN),    32'd0);
    check("rst_valid_b", observe(B_VALID), 32'd0);
    rst = 1'b0;

    // r2 = 5, r3 = 7
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd5;
    step();
    wb_addr = 4'd3; wb_data = 32'd7;
    step();
    wb_en = 1'b0;

    // ADD r1, r2, r3
    set_instr(32'hE0821003, 32'h104);
    #1 check("add_haz_a", 32'(haz_a), 32'd0);
    expect_out("add_valid", A_VALID, 1);
    expect_out("add_cmd",   A_CMD,   4'b0010);
    expect_out("add_wben",  A_WBEN,  1);
    expect_out("add_dest",  A_DEST,  1);
    expect_out("add_rn",    A_RN,    5);
    expect_out("add_rm",    A_RM,    7);
    expect_out("add_pc",    A_PC,    32'h104);
    step();

    // MOV r0, #0x14 with EXE writing r0: Rn unused, no hazard
    set_instr(32'hE3A00014, 32'h108);
    exe_wb_en = 1'b1; exe_dest = 4'd0;
    #1 check("mov_haz_a", 32'(haz_a), 32'd0);
    expect_out("mov_cmd",   A_CMD,   4'b0001);
    expect_out("mov_imm",   A_IMM,   1);
    expect_out("mov_shift", A_SHIFT, 32'h014);
    expect_out("mov_valid", A_VALID, 1);
    step();
    exe_wb_en = 1'b0;

    // B +2
    set_instr(32'hEA000002, 32'h10C);
    expect_out("b_branch", A_BR,    1);
    expect_out("b_simm",   A_SIMM,  32'h000002);
    expect_out("b_valid",  A_VALID, 1);
    expect_out("b_wben",   A_WBEN,  0);
    step();

    // BEQ with Z=0 fails
    set_instr(32'h0A000002, 32'h110);
    status_in = 4'b0000;
    expect_out("beq_valid",  A_VALID, 0);
    expect_out("beq_branch", A_BR,    0);
    step();

    // EXE hazard on Rn: dut_a stalls, dut_b forwards
    set_instr(32'hE0821003, 32'h114);
    exe_wb_en = 1'b1; exe_dest = 4'd2;
    #1 check("exe_haz_a", 32'(haz_a), 32'd1);
    check("exe_haz_b", 32'(haz_b), 32'd0);
    expect_out("exe_valid_a", A_VALID, 0);
    expect_out("exe_cmd_a",   A_CMD,   0);
    expect_out("exe_dest_a",  A_DEST,  1);
    expect_out("exe_hcyc_a",  A_HCYC,  1);
    expect_out("exe_valid_b", B_VALID, 1);
    expect_out("exe_cmd_b",   B_CMD,   4'b0010);
    expect_out("exe_hcyc_b",  B_HCYC,  0);
    step();

    // load-use: both stall
    exe_mem_read = 1'b1;
    #1 check("ld_haz_b", 32'(haz_b), 32'd1);
    expect_out("ld_hcyc_a",  A_HCYC,  2);
    expect_out("ld_hcyc_b",  B_HCYC,  1);
    expect_out("ld_valid_b", B_VALID, 0);
    step();

    // hazard cleared: normal load
    exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    #1 check("clr_haz_a", 32'(haz_a), 32'd0);
    expect_out("clr_valid_a", A_VALID, 1);
    expect_out("clr_cmd_a",   A_CMD,   4'b0010);
    step();

    // MEM-stage hazard on Rm: only dut_a
    mem_wb_en = 1'b1; mem_dest = 4'd3;
    #1 check("mem_haz_a", 32'(haz_a), 32'd1);
    check("mem_haz_b", 32'(haz_b), 32'd0);
    expect_out("mem_hcyc_a",  A_HCYC,  3);
    expect_out("mem_valid_a", A_VALID, 0);
    expect_out("mem_hcyc_b",  B_HCYC,  1);
    step();
    mem_wb_en = 1'b0;

    // flush beats freeze and hazard
    flush = 1'b1; freeze = 1'b1;
    exe_wb_en = 1'b1; exe_dest = 4'd2; exe_mem_read = 1'b1;
    #1 check("fl_haz_a", 32'(haz_a), 32'd0);
    check("fl_haz_b", 32'(haz_b), 32'd0);
    expect_out("fl_valid_a", A_VALID, 0);
    expect_out("fl_cmd_a",   A_CMD,   0);
    expect_out("fl_dest_a",  A_DEST,  1);
    expect_out("fl_hcyc_a",  A_HCYC,  3);
    expect_out("fl_hcyc_b",  B_HCYC,  1);
    step();
    flush = 1'b0; freeze = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;

    // good load, then freeze for three cycles with a pending hazard
    set_instr(32'hE0821003, 32'h200);
    expect_out("pre_valid", A_VALID, 1);
    step();
    freeze = 1'b1;
    set_instr(32'hE3A00014, 32'h300);
    instr_in = 32'hE0801002;
    exe_wb_en = 1'b1; exe_dest = 4'd2;
    #1 check("frz_haz_a", 32'(haz_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      expect_out("frz_valid", A_VALID, 1);
      expect_out("frz_pc",    A_PC,    32'h200);
      expect_out("frz_cmd",   A_CMD,   4'b0010);
      expect_out("frz_rn",    A_RN,    5);
      expect_out("frz_hcyc",  A_HCYC,  3);
      step();
    end
    freeze = 1'b0; exe_wb_en = 1'b0;

    // write r3 = 0x55 while reading it
    set_instr(32'hE0821003, 32'h204);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h55;
    expect_out("byp_rm_a", A_RM, 32'h55);
    expect_out("byp_rm_b", B_RM, 32'd7);
    step();
    wb_addr = 4'd0; wb_data = 32'h1234;
    expect_out("post_rm_b", B_RM, 32'h55);
    step();
    wb_en = 1'b0;

    // ADD r1, r0, r3: r0 is writable
    set_instr(32'hE0801003, 32'h208);
    expect_out("r0_rn", A_RN, 32'h1234);
    expect_out("r0_rm", A_RM, 32'h55);
    step();

    // LDR r2, [r1, #4]
    set_instr(32'hE5912004, 32'h20C);
    expect_out("ldr_memrd", A_MEMRD, 1);
    expect_out("ldr_wben",  A_WBEN,  1);
    expect_out("ldr_cmd",   A_CMD,   4'b0010);
    expect_out("ldr_dest",  A_DEST,  2);
    step();

    // mode 11 unsupported
    set_instr(32'hEC000000, 32'h210);
    expect_out("m11_valid", A_VALID, 0);
    expect_out("m11_wben",  A_WBEN,  0);
    step();

    // STR r2, [r1, #4]: src2 is Rd
    set_instr(32'hE5812004, 32'h214);
    expect_out("str_memwr", A_MEMWR, 1);
    expect_out("str_wben",  A_WBEN,  0);
    expect_out("str_rm",    A_RM,    5);
    expect_out("str_valid", A_VALID, 1);
    step();

    // STR stalls on Rd, then reset arrives mid-stall
    exe_wb_en = 1'b1; exe_dest = 4'd2;
    #1 check("str_haz_a", 32'(haz_a), 32'd1);
    rst = 1'b1;
    #1 check("rs_haz_a", 32'(haz_a), 32'd0);
    check("rs_hcyc_a",  observe(A_HCYC),  32'd0);
    check("rs_valid_a", observe(A_VALID), 32'd0);
    check("rs_valid_b", observe(B_VALID), 32'd0);
    @(negedge clk);
    rst = 1'b0; if_valid = 1'b0; exe_wb_en = 1'b0;
    step();

    set_instr(32'hE0821003, 32'h400);
    expect_out("rs_rn",    A_RN,    0);
    expect_out("rs_rm",    A_RM,    0);
    expect_out("rs_valid", A_VALID, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
